// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with line refill over a valid/ready memory port
//
// Purpose: serves fetch requests from a direct-mapped array. A hit answers one
// cycle after the request. A miss requests the whole line from memory, takes
// one word per response beat in ascending order, then answers with the
// requested word. flush invalidates every line.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   req_valid/req_ready     fetch request handshake, req_addr = byte address
//   resp_valid/resp_instr   one-cycle response pulse with the instruction word
//   flush                   invalidate all lines (level)
//   mem_req_valid/ready     refill request handshake, mem_req_addr = line address
//   mem_resp_valid/data     one refill word per valid beat
module icache_dm #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_instr,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int LOW_W = OFF_W + 2;
  localparam int TAG_W = ADDR_W - LOW_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_DATA, MISS_RESP} state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;
  logic [OFF_W-1:0] cnt_q;
  logic             flush_pend_q;
  logic [31:0]      word_q;
  logic             resp_valid_q;
  logic [31:0]      resp_instr_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic             beat;
  logic             last_beat;
  logic             unused_byte_bits;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[LOW_W +: IDX_W];
  assign req_off = req_addr[2 +: OFF_W];
  assign unused_byte_bits = ^req_addr[1:0];

  // A flush in the same cycle as a request forces that request to miss.
  assign hit       = valid_q[req_idx] && (tag_arr[req_idx] == req_tag) && !flush;
  assign beat      = (state_q == MISS_DATA) && mem_resp_valid;
  assign last_beat = beat && (cnt_q == LAST_CNT);

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !hit) begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q, {LOW_W{1'b0}}};
        if (mem_req_ready) begin
          state_d = MISS_DATA;
        end
      end
      MISS_DATA: begin
        if (last_beat) begin
          state_d = MISS_RESP;
        end
      end
      MISS_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end
          if (req_valid) begin
            tag_q <= req_tag;
            idx_q <= req_idx;
            off_q <= req_off;
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_instr_q <= data_arr[{req_idx, req_off}];
            end
          end
        end
        MISS_REQ: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_req_ready) begin
            cnt_q <= '0;
          end
        end
        MISS_DATA: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_resp_valid) begin
            cnt_q <= cnt_q + OFF_W'(1);
            if (cnt_q == off_q) begin
              word_q <= mem_resp_data;
            end
            if (cnt_q == LAST_CNT) begin
              valid_q[idx_q] <= 1'b1;
              resp_valid_q   <= 1'b1;
              // The requested word may be the beat arriving right now.
              resp_instr_q   <= (cnt_q == off_q) ? mem_resp_data : word_q;
            end
          end
        end
        MISS_RESP: begin
          // A flush seen during the refill also drops the line just filled.
          if (flush || flush_pend_q) begin
            valid_q <= '0;
          end
          flush_pend_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Storage arrays carry no reset; writes only happen while refilling.
  always_ff @(posedge clk) begin
    if (beat) begin
      data_arr[{idx_q, cnt_q}] <= mem_resp_data;
      if (last_beat) begin
        tag_arr[idx_q] <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm against a line-level cache model
module tb_icache_dm;

  localparam int AW     = 32;
  localparam int LW     = 4;
  localparam int NL     = 16;
  localparam int LINE_B = LW * 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic [31:0]   resp_instr;
  logic          flush = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 1'b0;
  logic [31:0]   mem_resp_data = '0;

  icache_dm #(.ADDR_W(AW), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic        e_req_ready = 1'b1;
  logic        e_mem_req_valid = 1'b0;
  logic [31:0] e_mem_req_addr = '0;
  logic        e_resp_valid = 1'b0;
  logic [31:0] e_resp_instr = '0;

  // Cache model: which memory line each index currently holds
  bit          mvalid [NL];
  logic [31:0] mtag   [NL];

  int          last_resp_cyc = 0;
  logic [31:0] last_mreq_addr = '0;
  int          mreq_hs = 0;
  int          acc_cyc = 0;

  int opt_req_delay = 0;
  int opt_gap = 0;
  int opt_flush_beat = -1;
  int opt_reset_beats = 0;
  bit opt_junk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    case (w)
      32'h0:   return 32'h02a00313;
      32'h4:   return 32'h006383b3;
      32'h8:   return 32'h3e800e13;
      32'hc:   return 32'hffc3cae3;
      default: return (w * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    e_resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, e_req_ready});
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mem_req_valid});
      if (e_mem_req_valid || !reset) chk("mem_req_addr", mem_req_addr, e_mem_req_addr);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp_valid});
      chk("resp_instr", resp_instr, e_resp_instr);
      if (resp_valid) last_resp_cyc = cyc;
      if (mem_req_valid) last_mreq_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready) mreq_hs++;
    end
  end

  task automatic idle(input bit fl, input bit junk);
    req_valid = 1'b0;
    flush = fl;
    mem_resp_valid = junk;
    mem_resp_data = $urandom;
    if (fl) clear_model();
    step();
    flush = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic reset_abort();
    reset = 1'b0;
    mem_resp_valid = 1'b0;
    e_req_ready = 1'b1;
    e_mem_req_valid = 1'b0;
    e_mem_req_addr = '0;
    e_resp_valid = 1'b0;
    e_resp_instr = '0;
    clear_model();
    #1;
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_resp_instr", resp_instr, 32'd0);
    step();
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
  endtask

  // Presents one request in an idle cycle and plays memory until it is answered.
  task automatic fetch(input logic [31:0] addr, input bit fl);
    int          idx;
    logic [31:0] tag;
    logic [31:0] line;
    bit          hit;
    bit          fpend;
    int          g;
    idx  = int'((addr / LINE_B) % NL);
    tag  = addr / (LINE_B * NL);
    line = addr - (addr % LINE_B);
    hit  = !fl && mvalid[idx] && (mtag[idx] == tag);
    req_valid = 1'b1;
    req_addr = addr;
    flush = fl;
    if (fl) clear_model();
    step();
    acc_cyc = cyc;
    req_valid = 1'b0;
    flush = 1'b0;
    req_addr = $urandom;
    if (hit) begin
      e_resp_valid = 1'b1;
      e_resp_instr = mem_word(addr);
      return;
    end
    e_req_ready = 1'b0;
    e_mem_req_valid = 1'b1;
    e_mem_req_addr = line;
    fpend = 1'b0;
    for (int i = 0; i < opt_req_delay; i++) begin
      mem_req_ready = 1'b0;
      mem_resp_valid = opt_junk ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_resp_data = $urandom;
      step();
    end
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    step();
    mem_req_ready = 1'b0;
    e_mem_req_valid = 1'b0;
    for (int b = 0; b < LW; b++) begin
      g = (b == 0) ? 0 : ((opt_gap < 0) ? int'($urandom_range(0, 2)) : opt_gap);
      for (int k = 0; k < g; k++) begin
        mem_resp_valid = 1'b0;
        mem_resp_data = $urandom;
        step();
      end
      mem_resp_valid = 1'b1;
      mem_resp_data = mem_word(line + 32'(4 * b));
      if (b == opt_flush_beat) begin
        flush = 1'b1;
        fpend = 1'b1;
      end
      step();
      flush = 1'b0;
      mem_resp_valid = 1'b0;
      if (opt_reset_beats == b + 1) begin
        reset_abort();
        return;
      end
    end
    e_resp_valid = 1'b1;
    e_resp_instr = mem_word(addr);
    mvalid[idx] = 1'b1;
    mtag[idx] = tag;
    if (fpend) clear_model();
    step();
    e_req_ready = 1'b1;
  endtask

  task automatic default_opts();
    opt_req_delay = 0;
    opt_gap = 0;
    opt_flush_beat = -1;
    opt_reset_beats = 0;
    opt_junk = 1'b0;
  endtask

  initial begin
    int h0;
    logic [31:0] a;
    clear_model();
    for (int i = 0; i < NL; i++) mtag[i] = '0;
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_instr", resp_instr, 32'd0);
    chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("reset_mem_req_addr", mem_req_addr, 32'd0);
    reset = 1'b1;
    step();

    // Cold miss at 0x0
    default_opts();
    fetch(32'h0, 1'b0);
    chk("cold_latency", 32'(last_resp_cyc + 1 - acc_cyc), 32'd6);
    chk("cold_ready_back", 32'(cyc + 1 - acc_cyc), 32'd7);
    chk("cold_mem_req_addr", last_mreq_addr, 32'h0);
    chk("cold_instr", resp_instr, 32'h02a00313);

    // Back-to-back hits
    h0 = mreq_hs;
    fetch(32'h4, 1'b0);
    chk("hit4_valid", {31'b0, resp_valid}, 32'd1);
    chk("hit4_instr", resp_instr, 32'h006383b3);
    fetch(32'h8, 1'b0);
    chk("hit8_instr", resp_instr, 32'h3e800e13);
    fetch(32'hc, 1'b0);
    chk("hitc_instr", resp_instr, 32'hffc3cae3);
    chk("hitc_latency", 32'(cyc - acc_cyc + 1), 32'd1);
    idle(1'b0, 1'b0);
    chk("hits_no_mem_req", 32'(mreq_hs - h0), 32'd0);

    // Conflict on index 0
    h0 = mreq_hs;
    fetch(32'h100, 1'b0);
    chk("conflict_mem_req_addr", last_mreq_addr, 32'h100);
    fetch(32'h0, 1'b0);
    chk("conflict_remiss", 32'(mreq_hs - h0), 32'd2);
    chk("conflict_instr", resp_instr, 32'h02a00313);

    // Backpressure on request and gaps between beats
    opt_req_delay = 3;
    opt_gap = 2;
    opt_junk = 1'b1;
    fetch(32'h2A8, 1'b0);
    chk("bp_latency", 32'(last_resp_cyc + 1 - acc_cyc), 32'd15);
    chk("bp_mem_req_addr", last_mreq_addr, 32'h2A0);
    default_opts();

    // Flush in idle, then flush during refill
    fetch(32'h4, 1'b0);
    idle(1'b1, 1'b0);
    h0 = mreq_hs;
    fetch(32'h4, 1'b0);
    chk("flush_idle_miss", 32'(mreq_hs - h0), 32'd1);
    opt_flush_beat = 1;
    fetch(32'h40, 1'b0);
    default_opts();
    h0 = mreq_hs;
    fetch(32'h40, 1'b0);
    chk("flush_refill_miss", 32'(mreq_hs - h0), 32'd1);

    // Reset in the middle of a refill
    opt_reset_beats = 2;
    fetch(32'h14, 1'b0);
    default_opts();
    h0 = mreq_hs;
    fetch(32'h0, 1'b0);
    chk("post_reset_miss", 32'(mreq_hs - h0), 32'd1);
    chk("post_reset_instr", resp_instr, 32'h02a00313);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        idle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end else if (r < 3) begin
        idle(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        a = 32'($urandom_range(0, 3) * 256 + $urandom_range(0, NL - 1) * LINE_B
                 + $urandom_range(0, LW - 1) * 4 + $urandom_range(0, 3));
        opt_req_delay = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        opt_gap = -1;
        opt_junk = 1'b1;
        opt_flush_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
        fetch(a, 1'($urandom_range(0, 15) == 0));
      end
    end
    default_opts();
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
